// File: rtl/axi_slv_pkg.sv
// Shared constants and FSM state encodings for the single-beat AXI SRAM slave.
package axi_slv_pkg;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} rd_state_e;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wr_state_e;

endpackage

// File: rtl/sram_bank.sv
// Synchronous 1-read/1-write byte-enable RAM, 2^ADDR_W x 32, write-first on a
// same-word collision so a read launched on the write edge sees the new bytes.
module sram_bank #(
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [31:0]       rdata,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [31:0]       wdata,
  input  logic [3:0]        wstrb
);

  logic [31:0] mem_q [0:(1<<ADDR_W)-1];
  logic [31:0] rdata_q;
  logic [31:0] rd_word_d;

  always_comb begin
    rd_word_d = mem_q[raddr];
    if (we && (waddr == raddr)) begin
      for (int b = 0; b < 4; b++) begin
        if (wstrb[b]) rd_word_d[8*b +: 8] = wdata[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (we && wstrb[b]) mem_q[waddr][8*b +: 8] <= wdata[8*b +: 8];
    end
  end

  // Read register is cleared on reset so the slave presents rdata=0 afterwards.
  always_ff @(posedge clk) begin
    if (rst)     rdata_q <= '0;
    else if (re) rdata_q <= rd_word_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/axi_sram_slave.sv
// Single-beat AXI4 SRAM slave with independent read and write FSMs.
// Define AXI_SLAVE_LAT_EN to stretch the read wait state by RD_LAT cycles.
module axi_sram_slave
  import axi_slv_pkg::*;
#(
  parameter int ADDR_W = 12,
  parameter int RD_LAT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  arid,
  input  logic [31:0] araddr,
  input  logic        arvalid,
  output logic        arready,
  output logic [3:0]  rid,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rlast,
  output logic        rvalid,
  input  logic        rready,
  input  logic [3:0]  awid,
  input  logic [31:0] awaddr,
  input  logic        awvalid,
  output logic        awready,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wvalid,
  output logic        wready,
  output logic [3:0]  bid,
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready
);

  rd_state_e         r_state_q;
  logic              arready_q, rvalid_q;
  logic [3:0]        rid_q;
  logic [ADDR_W-1:0] ridx_q;
  logic              ar_hs, rd_en;

  wr_state_e         w_state_q;
  logic              awready_q, wready_q, bvalid_q;
  logic [3:0]        bid_q;
  logic [ADDR_W-1:0] widx_q;
  logic [31:0]       wdata_q;
  logic [3:0]        wstrb_q;
  logic              aw_hs, w_hs, mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [31:0]       mem_wdata;
  logic [3:0]        mem_wstrb;

  logic              unused_addr_bits;
  assign unused_addr_bits = ^{araddr[31:ADDR_W+2], araddr[1:0], awaddr[31:ADDR_W+2], awaddr[1:0]};

  assign ar_hs = arvalid && arready_q;

`ifdef AXI_SLAVE_LAT_EN
  localparam int CNT_W = (RD_LAT < 2) ? 1 : $clog2(RD_LAT + 1);
  logic [CNT_W-1:0] rcnt_q;

  assign rd_en = (r_state_q == R_WAIT) && (rcnt_q == '0);

  always_ff @(posedge clk) begin
    if (rst)                                  rcnt_q <= '0;
    else if (ar_hs)                           rcnt_q <= CNT_W'(RD_LAT);
    else if (r_state_q == R_WAIT && !rd_en)   rcnt_q <= rcnt_q - 1'b1;
  end
`else
  logic [31:0] unused_rd_lat;
  assign unused_rd_lat = RD_LAT;
  assign rd_en = (r_state_q == R_WAIT);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state_q <= R_IDLE;
      arready_q <= 1'b1;
      rvalid_q  <= 1'b0;
      rid_q     <= '0;
    end else begin
      case (r_state_q)
        R_IDLE: if (arvalid) begin
          rid_q     <= arid;
          arready_q <= 1'b0;
          r_state_q <= R_WAIT;
        end
        R_WAIT: if (rd_en) begin
          rvalid_q  <= 1'b1;
          r_state_q <= R_DATA;
        end
        R_DATA: if (rready) begin
          rvalid_q  <= 1'b0;
          arready_q <= 1'b1;
          r_state_q <= R_IDLE;
        end
        default: r_state_q <= R_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (ar_hs) ridx_q <= araddr[ADDR_W+1:2];
  end

  // A channel counts as present if it is handshaking now or was captured earlier.
  assign aw_hs     = awvalid && awready_q;
  assign w_hs      = wvalid && wready_q;
  assign mem_we    = (w_state_q != W_RESP) && (aw_hs || !awready_q) && (w_hs || !wready_q);
  assign mem_waddr = aw_hs ? awaddr[ADDR_W+1:2] : widx_q;
  assign mem_wdata = w_hs ? wdata : wdata_q;
  assign mem_wstrb = w_hs ? wstrb : wstrb_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      w_state_q <= W_IDLE;
      awready_q <= 1'b1;
      wready_q  <= 1'b1;
      bvalid_q  <= 1'b0;
      bid_q     <= '0;
    end else begin
      case (w_state_q)
        W_IDLE, W_DATA: begin
          if (aw_hs) begin
            awready_q <= 1'b0;
            bid_q     <= awid;
          end
          if (w_hs) wready_q <= 1'b0;
          if (mem_we) begin
            bvalid_q  <= 1'b1;
            w_state_q <= W_RESP;
          end else if (aw_hs || w_hs) begin
            w_state_q <= W_DATA;
          end
        end
        W_RESP: if (bready) begin
          bvalid_q  <= 1'b0;
          awready_q <= 1'b1;
          wready_q  <= 1'b1;
          w_state_q <= W_IDLE;
        end
        default: w_state_q <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (aw_hs) widx_q <= awaddr[ADDR_W+1:2];
    if (w_hs) begin
      wdata_q <= wdata;
      wstrb_q <= wstrb;
    end
  end

  sram_bank #(.ADDR_W(ADDR_W)) u_bank (
    .clk   (clk),
    .rst   (rst),
    .re    (rd_en),
    .raddr (ridx_q),
    .rdata (rdata),
    .we    (mem_we),
    .waddr (mem_waddr),
    .wdata (mem_wdata),
    .wstrb (mem_wstrb)
  );

  assign arready = arready_q;
  assign rid     = rid_q;
  assign rresp   = RESP_OKAY;
  assign rlast   = rvalid_q;
  assign rvalid  = rvalid_q;
  assign awready = awready_q;
  assign wready  = wready_q;
  assign bid     = bid_q;
  assign bresp   = RESP_OKAY;
  assign bvalid  = bvalid_q;

endmodule

// File: tb/tb_axi_sram_slave.sv
// Directed self-checking bench for axi_sram_slave (default ADDR_W=12, RD_LAT=2).
module tb_axi_sram_slave;

`ifdef AXI_SLAVE_LAT_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 2;
`endif

  logic        clk, rst;
  logic [3:0]  arid, rid, awid, bid, wstrb;
  logic [31:0] araddr, rdata, awaddr, wdata;
  logic        arvalid, arready, rlast, rvalid, rready;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic [1:0]  rresp, bresp;
  logic [31:0] rd_val;

  int n_checks = 0;
  int n_errors = 0;

  axi_sram_slave dut (
    .clk(clk), .rst(rst),
    .arid(arid), .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rvalid(input string tag);
    int k = 0;
    while (rvalid !== 1'b1 && k < 20) begin
      tick();
      k++;
    end
    chk(tag, 32'(rvalid), 32'd1);
  endtask

  task automatic wait_bvalid(input string tag);
    int k = 0;
    while (bvalid !== 1'b1 && k < 20) begin
      tick();
      k++;
    end
    chk(tag, 32'(bvalid), 32'd1);
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          input logic [3:0] id);
    awaddr = a; awid = id; awvalid = 1'b1;
    wdata = d; wstrb = s; wvalid = 1'b1;
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    wait_bvalid("wr_bvalid");
    chk("wr_bid", 32'(bid), 32'(id));
    bready = 1'b1;
    tick();
    bready = 1'b0;
  endtask

  task automatic do_read(input logic [31:0] a, input logic [3:0] id, output logic [31:0] d);
    araddr = a; arid = id; arvalid = 1'b1;
    tick();
    arvalid = 1'b0;
    wait_rvalid("rd_rvalid");
    d = rdata;
    chk("rd_rid", 32'(rid), 32'(id));
    rready = 1'b1;
    tick();
    rready = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    arid = '0; araddr = '0; arvalid = 1'b0; rready = 1'b0;
    awid = '0; awaddr = '0; awvalid = 1'b0;
    wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;
    tick();
    tick();
    chk("rst_arready", 32'(arready), 32'd1);
    chk("rst_awready", 32'(awready), 32'd1);
    chk("rst_wready",  32'(wready),  32'd1);
    chk("rst_rvalid",  32'(rvalid),  32'd0);
    chk("rst_bvalid",  32'(bvalid),  32'd0);
    chk("rst_rdata",   rdata,        32'd0);
    chk("rst_rid",     32'(rid),     32'd0);
    chk("rst_bid",     32'(bid),     32'd0);
    rst = 1'b0;
    tick();

    // AW and W in the same cycle
    awid = 4'h5; awaddr = 32'h1000; awvalid = 1'b1;
    wdata = 32'hDEADBEEF; wstrb = 4'hF; wvalid = 1'b1;
    chk("same_awready", 32'(awready), 32'd1);
    chk("same_wready",  32'(wready),  32'd1);
    chk("same_bvalid0", 32'(bvalid),  32'd0);
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    chk("same_bvalid", 32'(bvalid), 32'd1);
    chk("same_bresp",  32'(bresp),  32'd0);
    chk("same_bid",    32'(bid),    32'd5);
    chk("same_awready_busy", 32'(awready), 32'd0);
    bready = 1'b1;
    tick();
    bready = 1'b0;
    chk("same_bvalid_done", 32'(bvalid),  32'd0);
    chk("same_awready_back", 32'(awready), 32'd1);
    chk("same_wready_back",  32'(wready),  32'd1);

    // W three cycles ahead of AW, low two byte lanes
    wdata = 32'h0000ABCD; wstrb = 4'b0011; wvalid = 1'b1;
    tick();
    wvalid = 1'b0;
    chk("wfirst_wready",  32'(wready),  32'd0);
    chk("wfirst_awready", 32'(awready), 32'd1);
    chk("wfirst_bvalid",  32'(bvalid),  32'd0);
    tick();
    tick();
    chk("wfirst_bvalid_wait", 32'(bvalid), 32'd0);
    awid = 4'h3; awaddr = 32'h1000; awvalid = 1'b1;
    tick();
    awvalid = 1'b0;
    chk("wfirst_bvalid_resp", 32'(bvalid), 32'd1);
    chk("wfirst_bid",         32'(bid),    32'd3);
    bready = 1'b1;
    tick();
    bready = 1'b0;

    // Read back with latency check, then back-pressure for 5 cycles
    arid = 4'h7; araddr = 32'h1000; arvalid = 1'b1;
    chk("rd_arready_idle", 32'(arready), 32'd1);
    tick();
    arvalid = 1'b0;
    chk("rd_arready_busy", 32'(arready), 32'd0);
    for (int i = 1; i < LAT; i++) begin
      chk("rd_rvalid_early", 32'(rvalid), 32'd0);
      tick();
    end
    chk("rd_rvalid_lat", 32'(rvalid), 32'd1);
    chk("rd_merge_data", rdata,       32'hDEADABCD);
    chk("rd_rid7",       32'(rid),    32'd7);
    chk("rd_rresp",      32'(rresp),  32'd0);
    chk("rd_rlast",      32'(rlast),  32'd1);
    arid = 4'h9; araddr = 32'h2000; arvalid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("hold_rvalid",  32'(rvalid),  32'd1);
      chk("hold_rdata",   rdata,        32'hDEADABCD);
      chk("hold_rid",     32'(rid),     32'd7);
      chk("hold_arready", 32'(arready), 32'd0);
    end
    arvalid = 1'b0;
    rready = 1'b1;
    tick();
    rready = 1'b0;
    chk("accept_rvalid",  32'(rvalid),  32'd0);
    chk("accept_arready", 32'(arready), 32'd1);

    // Aliased address with wstrb=0 changes nothing; then upper lanes only
    do_write(32'h0000_5000, 32'hFFFFFFFF, 4'h0, 4'h1);
    do_read(32'h1000, 4'h2, rd_val);
    chk("strb0_data", rd_val, 32'hDEADABCD);
    do_write(32'h0000_5000, 32'h0BADF00D, 4'hC, 4'h2);
    do_read(32'h1000, 4'h4, rd_val);
    chk("alias_upper_data", rd_val, 32'h0BADABCD);

    // Read and write of the same word issued together
    araddr = 32'h2000; arid = 4'h2; arvalid = 1'b1;
    awaddr = 32'h2000; awid = 4'h6; awvalid = 1'b1;
    wdata = 32'h12345678; wstrb = 4'hF; wvalid = 1'b1;
    tick();
    arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
    chk("coll_bvalid", 32'(bvalid), 32'd1);
    wait_rvalid("coll_rvalid");
    chk("coll_rdata", rdata, 32'h12345678);
    rready = 1'b1; bready = 1'b1;
    tick();
    rready = 1'b0; bready = 1'b0;

    // Write landing on the edge where the read samples memory
    do_write(32'h3000, 32'hA5A5A5A5, 4'hF, 4'h1);
    araddr = 32'h3000; arid = 4'h4; arvalid = 1'b1;
    tick();
    arvalid = 1'b0;
    awaddr = 32'h3000; awid = 4'h8; awvalid = 1'b1;
    wdata = 32'h11223344; wstrb = 4'b0101; wvalid = 1'b1;
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    wait_rvalid("late_rvalid");
    chk("late_rdata", rdata, 32'hA522A544);
    rready = 1'b1; bready = 1'b1;
    tick();
    rready = 1'b0; bready = 1'b0;

    // Reset while both responses are pending
    araddr = 32'h1000; arid = 4'hB; arvalid = 1'b1;
    awaddr = 32'h4000; awid = 4'hA; awvalid = 1'b1;
    wdata = 32'h00000077; wstrb = 4'hF; wvalid = 1'b1;
    tick();
    arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
    wait_rvalid("pend_rvalid");
    chk("pend_bvalid", 32'(bvalid), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_rvalid",  32'(rvalid),  32'd0);
    chk("mid_rst_bvalid",  32'(bvalid),  32'd0);
    chk("mid_rst_arready", 32'(arready), 32'd1);
    chk("mid_rst_awready", 32'(awready), 32'd1);
    chk("mid_rst_wready",  32'(wready),  32'd1);
    chk("mid_rst_rdata",   rdata,        32'd0);
    chk("mid_rst_rid",     32'(rid),     32'd0);
    chk("mid_rst_bid",     32'(bid),     32'd0);
    tick();
    do_read(32'h1000, 4'h3, rd_val);
    chk("mem_kept", rd_val, 32'h0BADABCD);
    do_read(32'h4000, 4'h5, rd_val);
    chk("mem_pre_rst_write", rd_val, 32'h00000077);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
